// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared widths, default depth and entry layout
// for the instruction fetch queue and its FIFOs.
package inst_fetch_queue_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;
   localparam int IfqDepth    = 4;

   // Pointer width for a power-of-two FIFO of the given depth.
   // Counters are one bit wider so that "full" is representable.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   typedef struct packed {
      logic [InstAddrBus-1:0] pc;
      logic [InstBus-1:0]     inst;
   } iq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fetch.sv
// fetch_fifo: synchronous FIFO with push, pop, clear, full, empty, count.
// Ports: clk/rst_n, push_i+wdata_i, pop_i, clear_i, rdata_o (head), flags.
module fetch_fifo
   import inst_fetch_queue_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = IfqDepth
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   input  logic                   clear_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = wdata_i;
            wr_d        = wr_q + PW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: issues in-order fetches, tags responses, buffers them.
// Ports: PC side (pc_i, ce_i, stall_req_o), memory bus, decode side, flush_i.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = IfqDepth
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [InstAddrBus-1:0] pc_i,
   input  logic                   ce_i,
   input  logic                   flush_i,
   output logic                   stall_req_o,
   output logic                   mem_req_o,
   output logic [InstAddrBus-1:0] mem_addr_o,
   input  logic                   mem_gnt_i,
   input  logic                   mem_rvalid_i,
   input  logic [InstBus-1:0]     mem_rdata_i,
   input  logic                   id_stall_i,
   output logic                   inst_valid_o,
   output logic [InstBus-1:0]     inst_o,
   output logic [InstAddrBus-1:0] inst_pc_o
);

   localparam int CW = ptr_w(DEPTH) + 1;
   localparam int SW = CW + 2;

   logic [CW-1:0]          cnt, live, stale;
   logic [CW-1:0]          drop_q, drop_d;
   logic [SW-1:0]          occ;
   logic                   fetch_act, grant;
   logic                   resp_live, iq_pop;
   logic                   aq_full, aq_empty;
   logic                   iq_full, iq_empty;
   logic [InstAddrBus-1:0] aq_head;
   iq_entry_t              iq_in, iq_head;

   // Rst gates the request so the bus is quiet while held in reset.
   assign fetch_act = Rst & ce_i & ~flush_i;
   assign occ = SW'(cnt) + SW'(live) + SW'(drop_q);

   // Every slot held by a buffered, live or stale request counts against
   // DEPTH, so a response always finds room in iq.
   assign mem_req_o = fetch_act & ~aq_full & ~iq_full
                    & (occ < SW'(DEPTH));
   assign mem_addr_o  = pc_i;
   assign grant       = mem_req_o & mem_gnt_i;
   assign stall_req_o = fetch_act & ~grant;

   assign resp_live = mem_rvalid_i & ~flush_i
                    & (drop_q == '0) & ~aq_empty;

   assign inst_valid_o = ~iq_empty & ~flush_i;
   assign iq_pop       = inst_valid_o & ~id_stall_i;
   assign inst_o       = inst_valid_o ? iq_head.inst : '0;
   assign inst_pc_o    = inst_valid_o ? iq_head.pc : '0;

   assign iq_in.pc   = aq_head;
   assign iq_in.inst = mem_rdata_i;

   // On flush every live request becomes stale; one arriving this
   // cycle is retired immediately.
   assign stale = drop_q + live;

   always_comb begin
      drop_d = drop_q;
      if (flush_i) begin
         drop_d = stale - CW'(mem_rvalid_i && (stale != '0));
      end else if (mem_rvalid_i && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   fetch_fifo #(
      .WIDTH (InstAddrBus),
      .DEPTH (DEPTH)
   ) u_aq (
      .clk     (Clk),
      .rst_n   (Rst),
      .push_i  (grant),
      .wdata_i (pc_i),
      .pop_i   (resp_live),
      .clear_i (flush_i),
      .rdata_o (aq_head),
      .full_o  (aq_full),
      .empty_o (aq_empty),
      .count_o (live)
   );

   fetch_fifo #(
      .WIDTH ($bits(iq_entry_t)),
      .DEPTH (DEPTH)
   ) u_iq (
      .clk     (Clk),
      .rst_n   (Rst),
      .push_i  (resp_live),
      .wdata_i (iq_in),
      .pop_i   (iq_pop),
      .clear_i (flush_i),
      .rdata_o (iq_head),
      .full_o  (iq_full),
      .empty_o (iq_empty),
      .count_o (cnt)
   );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed bench with a small in-order memory and
// a PC stage that advances on grant and loads the target on flush.
module tb_inst_fetch_queue;

   logic        Clk;
   logic        Rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic        flush_i;
   logic        stall_req_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        id_stall_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;

   logic        gnt_en;
   logic        resp_en;
   logic [31:0] target;
   logic [31:0] pc_q;
   logic [31:0] pa [16];
   int          pw, pr, gcount, g0;
   int          errors, checks;

   inst_fetch_queue dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .pc_i         (pc_i),
      .ce_i         (ce_i),
      .flush_i      (flush_i),
      .stall_req_o  (stall_req_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .id_stall_i   (id_stall_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign pc_i         = pc_q;
   assign mem_gnt_i    = gnt_en & mem_req_o;
   assign mem_rvalid_i = resp_en && (pw != pr);
   assign mem_rdata_i  = inst_of(pa[pr % 16]);

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pw     <= 0;
         pr     <= 0;
         pc_q   <= '0;
         gcount <= 0;
      end else begin
         if (mem_req_o && mem_gnt_i) begin
            pa[pw % 16] <= mem_addr_o;
            pw          <= pw + 1;
            gcount      <= gcount + 1;
         end
         if (mem_rvalid_i) pr <= pr + 1;
         if (flush_i) pc_q <= target;
         else if (mem_req_o && mem_gnt_i) pc_q <= pc_q + 32'd4;
      end
   end

   task automatic chk1(input string tag, input logic obs,
                       input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk1({tag, "_valid"}, inst_valid_o, 1'b0);
      chk32({tag, "_inst"}, inst_o, 32'h0);
      chk32({tag, "_pc"}, inst_pc_o, 32'h0);
      chk1({tag, "_req"}, mem_req_o, 1'b0);
      chk1({tag, "_stall"}, stall_req_o, 1'b0);
   endtask

   task automatic chk_head(input string tag, input logic [31:0] a);
      chk1({tag, "_valid"}, inst_valid_o, 1'b1);
      chk32({tag, "_pc"}, inst_pc_o, a);
      chk32({tag, "_inst"}, inst_o, inst_of(a));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      errors = 0;
      checks = 0;
      Rst = 1'b0;
      ce_i = 1'b0;
      flush_i = 1'b0;
      id_stall_i = 1'b0;
      gnt_en = 1'b1;
      resp_en = 1'b1;
      target = '0;

      // reset: outputs quiet even with ce_i high
      #3 ce_i = 1'b1;
      #1 chk_zero("rst");
      ce_i = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      edge1();

      // zero-wait stream 0x00, 0x04, 0x08
      for (int k = 0; k < 5; k++) begin
         ce_i = (k < 3);
         #1;
         if (k < 3) begin
            chk1("str_req", mem_req_o, 1'b1);
            chk1("str_stall", stall_req_o, 1'b0);
            chk32("str_addr", mem_addr_o, 32'(4 * k));
         end
         if (k >= 2) chk_head("str", 32'(4 * (k - 2)));
         else chk1("str_early", inst_valid_o, 1'b0);
         edge1();
      end
      #1 chk1("str_end", inst_valid_o, 1'b0);

      // backpressure: four grants then stall, drain in order
      id_stall_i = 1'b1;
      ce_i = 1'b1;
      g0 = gcount;
      repeat (10) edge1();
      #1;
      chk32("bp_grants", 32'(gcount - g0), 32'd4);
      chk1("bp_req", mem_req_o, 1'b0);
      chk1("bp_stall", stall_req_o, 1'b1);
      id_stall_i = 1'b0;
      ce_i = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk_head("bp_drain", 32'(12 + 4 * k));
         edge1();
         #1;
      end
      chk1("bp_empty", inst_valid_o, 1'b0);

      // flush with three live requests, no response
      resp_en = 1'b0;
      ce_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 chk32("fl3_addr", mem_addr_o, 32'(28 + 4 * k));
         edge1();
      end
      flush_i = 1'b1;
      target = 32'h100;
      #1;
      chk1("fl3_req", mem_req_o, 1'b0);
      chk1("fl3_stall", stall_req_o, 1'b0);
      chk1("fl3_valid", inst_valid_o, 1'b0);
      edge1();
      flush_i = 1'b0;
      #1;
      chk1("fl3_req_tgt", mem_req_o, 1'b1);
      chk32("fl3_addr_tgt", mem_addr_o, 32'h100);
      edge1();
      resp_en = 1'b1;
      #1;
      chk1("fl3_throttle", mem_req_o, 1'b0);
      chk1("fl3_stall2", stall_req_o, 1'b1);
      edge1();
      ce_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk1("fl3_drop", inst_valid_o, 1'b0);
         edge1();
      end
      #1 chk_head("fl3_tgt", 32'h100);
      edge1();
      #1 chk1("fl3_empty", inst_valid_o, 1'b0);

      // flush coinciding with a response, two live
      id_stall_i = 1'b1;
      resp_en = 1'b0;
      ce_i = 1'b1;
      #1 chk32("flr_addr0", mem_addr_o, 32'h104);
      edge1();
      resp_en = 1'b1;
      #1 chk32("flr_addr1", mem_addr_o, 32'h108);
      edge1();
      resp_en = 1'b0;
      #1;
      chk_head("flr_held", 32'h104);
      chk32("flr_addr2", mem_addr_o, 32'h10C);
      edge1();
      flush_i = 1'b1;
      resp_en = 1'b1;
      target = 32'h200;
      #1;
      chk1("flr_valid", inst_valid_o, 1'b0);
      chk32("flr_inst", inst_o, 32'h0);
      edge1();
      flush_i = 1'b0;
      ce_i = 1'b0;
      #1 chk1("flr_drop", inst_valid_o, 1'b0);
      edge1();

      // simultaneous push and pop at cnt=2
      ce_i = 1'b1;
      #1;
      chk1("pp_valid0", inst_valid_o, 1'b0);
      chk32("pp_addr0", mem_addr_o, 32'h200);
      edge1();
      #1 chk32("pp_addr1", mem_addr_o, 32'h204);
      edge1();
      #1 chk32("pp_addr2", mem_addr_o, 32'h208);
      edge1();
      ce_i = 1'b0;
      id_stall_i = 1'b0;
      #1 chk_head("pp_h0", 32'h200);
      edge1();
      #1 chk_head("pp_h1", 32'h204);
      edge1();
      #1 chk_head("pp_h2", 32'h208);
      edge1();
      #1 chk1("pp_empty", inst_valid_o, 1'b0);

      // asynchronous reset mid-burst
      ce_i = 1'b1;
      #1 chk32("ar_addr", mem_addr_o, 32'h20C);
      edge1();
      #3;
      Rst = 1'b0;
      #1 chk_zero("ar");
      @(posedge Clk);
      #3;
      Rst = 1'b1;
      #1;
      chk1("ar_req", mem_req_o, 1'b1);
      chk32("ar_addr0", mem_addr_o, 32'h0);
      chk1("ar_valid", inst_valid_o, 1'b0);
      edge1();
      ce_i = 1'b0;
      #1 chk1("ar_valid1", inst_valid_o, 1'b0);
      edge1();
      #1 chk_head("ar_h0", 32'h0);
      edge1();
      #1 chk1("ar_empty", inst_valid_o, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
